tx_response_fifo: RTL and testbench

//  Single-clock byte FIFO with a TX-request handshake FSM. It sits in the REF_CLK domain,

---
 rtl/tx_response_fifo.sv | 136 +++++++++++++
 tb/tb_tx_response_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_response_fifo.sv
// Byte FIFO feeding the UART TX crossing; a request/busy handshake FSM holds each
// head byte level-stable until the synchronized TX busy confirms capture.
module tx_response_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int BUSY_TIMEOUT = 1023
) (
  input  logic                  TxFifo_CLK,
  input  logic                  TxFifo_RST,
  input  logic [DATA_WIDTH-1:0] TxFifo_WrData,
  input  logic                  TxFifo_Wr_en,
  input  logic                  TxFifo_Flush,
  input  logic                  TxFifo_Busy,
  output logic [DATA_WIDTH-1:0] TxFifo_TXPdata,
  output logic                  TxFifo_TX_Data_Valid,
  output logic                  TxFifo_Full,
  output logic                  TxFifo_Empty,
  output logic [ADDR_WIDTH:0]   TxFifo_Count,
  output logic                  TxFifo_Overflow,
  output logic                  TxFifo_Timeout
);

  // state | meaning
  // IDLE  | no request outstanding; launch one when a byte is queued and TX is idle
  // REQ   | Valid high, head byte presented, waiting for busy to rise
  // WAIT  | byte popped, waiting for TX busy to fall before the next request
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam int TW = (BUSY_TIMEOUT < 1) ? 1 : $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0]       TMR_LOAD = TW'(BUSY_TIMEOUT);
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [TW-1:0]         tmr_q;
  state_t                state_q;
  logic [DATA_WIDTH-1:0] txp_q;
  logic                  valid_q, ovf_q, timeout_q;
  logic                  full, empty, push, pop;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  // Full is judged before the edge, so a same-cycle pop never makes room for a write.
  assign push  = TxFifo_Wr_en & ~full & ~TxFifo_Flush;
  assign pop   = (state_q == S_REQ) & TxFifo_Busy & ~TxFifo_Flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (TxFifo_Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge TxFifo_CLK) begin
    if (push) mem_q[wr_ptr_q] <= TxFifo_WrData;
  end

  always_ff @(posedge TxFifo_CLK or negedge TxFifo_RST) begin
    if (!TxFifo_RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tmr_q     <= '0;
      state_q   <= S_IDLE;
      txp_q     <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= TxFifo_Wr_en & full & ~TxFifo_Flush;
      timeout_q <= 1'b0;
      if (TxFifo_Flush) begin
        state_q <= S_IDLE;
        valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!empty && !TxFifo_Busy) begin
              state_q <= S_REQ;
              txp_q   <= mem_q[rd_ptr_q];
              valid_q <= 1'b1;
              tmr_q   <= TMR_LOAD;
            end
          end
          S_REQ: begin
            if (TxFifo_Busy) begin
              state_q <= S_WAIT;
              valid_q <= 1'b0;
            end else if (tmr_q == '0) begin
              // Byte stays at the head, so the next IDLE pass retries it.
              state_q   <= S_IDLE;
              valid_q   <= 1'b0;
              timeout_q <= 1'b1;
            end else begin
              tmr_q <= tmr_q - 1'b1;
            end
          end
          S_WAIT: begin
            if (!TxFifo_Busy) state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign TxFifo_TXPdata       = txp_q;
  assign TxFifo_TX_Data_Valid = valid_q;
  assign TxFifo_Full          = full;
  assign TxFifo_Empty         = empty;
  assign TxFifo_Count         = count_q;
  assign TxFifo_Overflow      = ovf_q;
  assign TxFifo_Timeout       = timeout_q;

endmodule

// File: tb/tb_tx_response_fifo.sv
// Bench for tx_response_fifo: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations and a randomized TX-busy phase.
module tb_tx_response_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TO    = 1023;
  localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] wr_data;
  logic          wr_en, flush, busy;
  logic [DW-1:0] txp_o;
  logic          valid_o, full_o, empty_o, ovf_o, to_o;
  logic [AW:0]   cnt_o;

  tx_response_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .BUSY_TIMEOUT(TO)) dut (
    .TxFifo_CLK(clk), .TxFifo_RST(rst_n), .TxFifo_WrData(wr_data), .TxFifo_Wr_en(wr_en),
    .TxFifo_Flush(flush), .TxFifo_Busy(busy), .TxFifo_TXPdata(txp_o),
    .TxFifo_TX_Data_Valid(valid_o), .TxFifo_Full(full_o), .TxFifo_Empty(empty_o),
    .TxFifo_Count(cnt_o), .TxFifo_Overflow(ovf_o), .TxFifo_Timeout(to_o));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: contents as a queue, request lifecycle from the handshake rules.
  logic [DW-1:0] mq[$];
  int            m_phase = P_IDLE;
  int            m_age   = 0;
  logic [DW-1:0] m_txp   = '0;
  logic          m_valid = 1'b0, m_ovf = 1'b0, m_to = 1'b0;
  logic          m_full, m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_phase = P_IDLE; m_age = 0; m_txp = '0;
      m_valid = 1'b0; m_ovf = 1'b0; m_to = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_phase = P_IDLE; m_valid = 1'b0; m_ovf = 1'b0; m_to = 1'b0;
    end else begin
      m_full = (mq.size() == DEPTH);
      m_ovf  = wr_en && m_full;
      m_to   = 1'b0;
      m_pop  = 1'b0;
      case (m_phase)
        P_IDLE: if (mq.size() != 0 && !busy) begin
          m_phase = P_REQ; m_txp = mq[0]; m_valid = 1'b1; m_age = 0;
        end
        P_REQ: if (busy) begin
          m_phase = P_WAIT; m_valid = 1'b0; m_pop = 1'b1;
        end else if (m_age == TO) begin
          m_phase = P_IDLE; m_valid = 1'b0; m_to = 1'b1;
        end else begin
          m_age++;
        end
        default: if (!busy) m_phase = P_IDLE;
      endcase
      if (m_pop) void'(mq.pop_front());
      if (wr_en && !m_full) mq.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("m_valid", 32'(valid_o), 32'(m_valid));
      check("m_txpdata", 32'(txp_o), 32'(m_txp));
      check("m_count", 32'(cnt_o), 32'(mq.size()));
      check("m_full", 32'(full_o), 32'(mq.size() == DEPTH));
      check("m_empty", 32'(empty_o), 32'(mq.size() == 0));
      check("m_overflow", 32'(ovf_o), 32'(m_ovf));
      check("m_timeout", 32'(to_o), 32'(m_to));
    end
  end

  // Bytes handed to TX, as seen on the DUT handshake.
  logic [DW-1:0] obs[$];
  always @(posedge clk) begin
    if (rst_n === 1'b1 && !flush && valid_o && busy) obs.push_back(txp_o);
  end

  bit auto_tx = 1'b0;
  bit spur    = 1'b0;
  int busy_hold = 0;

  task automatic step(input logic w, input logic [DW-1:0] d, input logic f, input logic b);
    wr_en = w; wr_data = d; flush = f;
    if (auto_tx) begin
      if (busy) begin
        if (busy_hold == 0) busy = 1'b0;
        else busy_hold--;
      end else if (valid_o && $urandom_range(0, 2) != 0) begin
        busy = 1'b1; busy_hold = $urandom_range(0, 3);
      end else if (!valid_o && spur && $urandom_range(0, 15) == 0) begin
        busy = 1'b1; busy_hold = 0;
      end
    end else begin
      busy = b;
    end
    @(negedge clk);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    auto_tx = 1'b1;
    while (!(empty_o && !valid_o && !busy) && n < bound) begin
      step(1'b0, '0, 1'b0, 1'b0);
      n++;
    end
    if (n >= bound) check("drain_bound", 32'(n), 32'(bound - 1));
    auto_tx = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    logic [DW-1:0] exp3[$];
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0; busy = 1'b0;
    #1;
    check("rst_count", 32'(cnt_o), 0);
    check("rst_empty", 32'(empty_o), 1);
    check("rst_full", 32'(full_o), 0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_txpdata", 32'(txp_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single byte handshake
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    check("t1_count", 32'(cnt_o), 1);
    check("t1_valid_lat", 32'(valid_o), 0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("t1_valid", 32'(valid_o), 1);
    check("t1_txp", 32'(txp_o), 32'h A5);
    step(1'b0, '0, 1'b0, 1'b1);
    check("t1_pop_valid", 32'(valid_o), 0);
    check("t1_pop_count", 32'(cnt_o), 0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("t1_idle_empty", 32'(empty_o), 1);

    // Fill, overflow, drain in order
    obs.delete();
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check("t2_full", 32'(full_o), 1);
    check("t2_count", 32'(cnt_o), 8);
    step(1'b1, 8'h09, 1'b0, 1'b0);
    check("t2_ovf", 32'(ovf_o), 1);
    check("t2_ovf_count", 32'(cnt_o), 8);
    step(1'b0, '0, 1'b0, 1'b0);
    check("t2_ovf_pulse", 32'(ovf_o), 0);
    drain(500);
    check("t2_nbytes", 32'(obs.size()), 8);
    for (int i = 0; i < 8 && i < obs.size(); i++) check("t2_order", 32'(obs[i]), 32'(i + 1));

    // Pop while full drops the write; pop with room keeps both
    obs.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    check("t3_full_pop_count", 32'(cnt_o), 7);
    check("t3_full_pop_ovf", 32'(ovf_o), 1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("t3_req2_valid", 32'(valid_o), 1);
    check("t3_req2_txp", 32'(txp_o), 32'h12);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    check("t3_pushpop_count", 32'(cnt_o), 7);
    check("t3_pushpop_ovf", 32'(ovf_o), 0);
    drain(500);
    exp3 = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h55};
    check("t3_nbytes", 32'(obs.size()), 9);
    for (int i = 0; i < 9 && i < obs.size(); i++) check("t3_order", 32'(obs[i]), 32'(exp3[i]));

    // Busy timeout and retry
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    n = 0;
    while (!valid_o && n < 5) begin step(1'b0, '0, 1'b0, 1'b0); n++; end
    check("t4_req", 32'(valid_o), 1);
    n = 1;
    while (n < 2000) begin
      step(1'b0, '0, 1'b0, 1'b0);
      if (valid_o) n++;
      else break;
    end
    check("t4_req_cycles", 32'(n), 32'(TO + 1));
    check("t4_timeout", 32'(to_o), 1);
    step(1'b0, '0, 1'b0, 1'b0);
    check("t4_retry_valid", 32'(valid_o), 1);
    check("t4_retry_txp", 32'(txp_o), 32'h3C);
    check("t4_timeout_pulse", 32'(to_o), 0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    check("t4_empty", 32'(empty_o), 1);

    // Flush during REQ with a write
    for (int i = 0; i < 3; i++) step(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
    check("t5_req", 32'(valid_o), 1);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check("t5_valid", 32'(valid_o), 0);
    check("t5_count", 32'(cnt_o), 0);
    check("t5_empty", 32'(empty_o), 1);
    check("t5_ovf", 32'(ovf_o), 0);

    // Randomized traffic with a randomized TX
    auto_tx = 1'b1; spur = 1'b1;
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 63) == 0), 1'b0);
    spur = 1'b0;
    drain(800);

    // Async reset mid-WAIT
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 8'hD4, 1'b0, 1'b1);
    check("t6_pre_count", 32'(cnt_o), 1);
    check("t6_pre_txp", 32'(txp_o), 32'hC3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(valid_o), 0);
    check("t6_count", 32'(cnt_o), 0);
    check("t6_empty", 32'(empty_o), 1);
    check("t6_full", 32'(full_o), 0);
    check("t6_txp", 32'(txp_o), 0);
    check("t6_ovf", 32'(ovf_o), 0);
    check("t6_timeout", 32'(to_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    check("t6_after_valid", 32'(valid_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
